// File: rtl/imem_loader.sv
// Byte-stream program loader: receives a little-endian 16-bit word count followed by
// that many 32-bit words, and writes each word into instruction memory at consecutive
// word addresses while holding the core stalled.
module imem_loader #(
  parameter int unsigned DEPTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StWrite,
    StDone,
    StErr
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] index_q, index_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] asm_q, asm_d;
  logic        we_q, we_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        xfer;
  logic [15:0] len_full;
  logic [15:0] index_inc;

  // Ready is a pure decode of the receiving states.
  always_comb begin
    byte_ready = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StData);
  end

  // Next-state logic plus next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    index_d   = index_q;
    lane_d    = lane_q;
    asm_d     = asm_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    xfer      = byte_valid && byte_ready;
    len_full  = {byte_data, count_q[7:0]};
    index_inc = index_q + 16'd1;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) state_d = StLenLo;
      end
      StLenLo: begin
        if (xfer) begin
          count_d[7:0] = byte_data;
          state_d      = StLenHi;
        end
      end
      StLenHi: begin
        if (xfer) begin
          count_d = len_full;
          if (len_full == 16'd0) begin
            state_d = StDone;
          end else if ({16'd0, len_full} > DEPTH) begin
            state_d = StErr;
          end else begin
            state_d = StData;
            index_d = 16'd0;
            lane_d  = 2'd0;
          end
        end
      end
      StData: begin
        if (xfer) begin
          case (lane_q)
            2'd0: asm_d[7:0]   = byte_data;
            2'd1: asm_d[15:8]  = byte_data;
            2'd2: asm_d[23:16] = byte_data;
            default: asm_d[31:24] = byte_data;
          endcase
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            state_d = StWrite;
            // Capture the write beat now so the outputs are registered during WRITE.
            waddr_d = BASE_ADDR + ({16'd0, index_q} << 2);
            wdata_d = asm_d;
          end
        end
      end
      StWrite: begin
        index_d = index_inc;
        state_d = (index_inc == count_q) ? StDone : StData;
      end
      default: state_d = StIdle;
    endcase

    we_d   = (state_d == StWrite);
    hold_d = (state_d == StLenLo) || (state_d == StLenHi) ||
             (state_d == StData)  || (state_d == StWrite);
    done_d = (state_d == StDone);
    err_d  = (state_d == StErr);
  end

  // State and registered outputs; reset aborts any load in progress immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= 16'd0;
      index_q <= 16'd0;
      lane_q  <= 2'd0;
      asm_q   <= 32'd0;
      we_q    <= 1'b0;
      waddr_q <= 32'd0;
      wdata_q <= 32'd0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign core_hold  = hold_q;
  assign load_done  = done_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: two instances (base 0 and base 0x100) share one
// byte stream; expected writes are queued when a load is issued and popped by a monitor.
module tb_imem_loader;
  localparam int unsigned Depth = 32;
  localparam logic [31:0] Base0 = 32'h0000_0000;
  localparam logic [31:0] Base1 = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        br0, we0, hold0, done0, err0;
  logic        br1, we1, hold1, done1, err1;
  logic [31:0] waddr0, wdata0, waddr1, wdata1;

  imem_loader #(.DEPTH(Depth), .BASE_ADDR(Base0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(br0), .imem_we(we0), .imem_waddr(waddr0), .imem_wdata(wdata0),
    .core_hold(hold0), .load_done(done0), .load_err(err0)
  );

  imem_loader #(.DEPTH(Depth), .BASE_ADDR(Base1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(br1), .imem_we(we1), .imem_waddr(waddr1), .imem_wdata(wdata1),
    .core_hold(hold1), .load_done(done1), .load_err(err1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int data_bytes = 0;
  int wr_seen = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] e0, e1;
  logic [31:0] wbuf[Depth];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the expected queue, and may only
  // appear once four data bytes per word have been accepted.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (we0 === 1'b1) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write0 actual=%h required=none", waddr0);
        end else begin
          e0 = q0.pop_front();
          check("waddr0", waddr0, e0[63:32]);
          check("wdata0", wdata0, e0[31:0]);
        end
        wr_seen++;
        check("write_timing", data_bytes, 4 * wr_seen);
      end
      if (we1 === 1'b1) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write1 actual=%h required=none", waddr1);
        end else begin
          e1 = q1.pop_front();
          check("waddr1", waddr1, e1[63:32]);
          check("wdata1", wdata1, e1[31:0]);
        end
      end
    end
  end

  // Reference model: a count of 1..Depth writes word i at base + 4*i; anything else writes nothing.
  task automatic expect_load(input int cnt);
    if (cnt >= 1 && cnt <= int'(Depth)) begin
      for (int i = 0; i < cnt; i++) begin
        q0.push_back({Base0 + 32'(4 * i), wbuf[i]});
        q1.push_back({Base1 + 32'(4 * i), wbuf[i]});
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int stalls, input bit is_data,
                           input bit rnd_start);
    logic rdy;
    byte_valid = 1'b0;
    repeat (stalls) begin
      if (rnd_start) start = 1'($urandom % 2);
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    if (rnd_start) start = 1'($urandom % 2);
    for (int t = 0; ; t++) begin
      if (t == 50) begin
        total++; bad++;
        $display("FAIL byte_accept_timeout actual=no_ready required=ready");
        break;
      end
      @(negedge clk);
      rdy = br0;
      @(posedge clk); #1;
      if (rdy) break;
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    if (is_data) data_bytes++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    byte_valid = 1'b1;  // a byte alongside start must not be consumed
    byte_data = 8'hEE;
    @(posedge clk); #1;
    start = 1'b0;
    byte_valid = 1'b0;
    check("start_hold", hold0, 1'b1);
    check("start_ready", br0, 1'b1);
    check("start_done_clr", done0, 1'b0);
    check("start_err_clr", err0, 1'b0);
  endtask

  task automatic do_load(input int cnt, input int smin, input int smax, input bit rnd_start);
    logic [15:0] c;
    logic [31:0] w;
    c = cnt[15:0];
    data_bytes = 0;
    wr_seen = 0;
    expect_load(cnt);
    pulse_start();
    send_byte(c[7:0], $urandom_range(smax, smin), 1'b0, 1'b0);
    check("lenlo_hold", hold0, 1'b1);
    send_byte(c[15:8], $urandom_range(smax, smin), 1'b0, 1'b0);
    if (cnt == 0) begin
      check("zero_done", done0, 1'b1);
      check("zero_hold", hold0, 1'b0);
      check("zero_ready", br0, 1'b0);
      check("zero_err", err0, 1'b0);
    end else if (cnt > int'(Depth)) begin
      check("ovf_err", err0, 1'b1);
      check("ovf_hold", hold0, 1'b0);
      check("ovf_ready", br0, 1'b0);
      check("ovf_done", done0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
    end else begin
      for (int i = 0; i < cnt; i++) begin
        w = wbuf[i];
        for (int j = 0; j < 4; j++) begin
          send_byte(w[8*j +: 8], $urandom_range(smax, smin), 1'b1, rnd_start);
        end
        check("write_pulse", we0, 1'b1);
      end
      @(posedge clk); #1;
      check("end_done", done0, 1'b1);
      check("end_done1", done1, 1'b1);
      check("end_hold", hold0, 1'b0);
      check("end_we", we0, 1'b0);
    end
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, br0, 1'b0);
    check({tag, "_we"}, we0, 1'b0);
    check({tag, "_waddr"}, waddr0, 32'd0);
    check({tag, "_wdata"}, wdata0, 32'd0);
    check({tag, "_hold"}, hold0, 1'b0);
    check({tag, "_done"}, done0, 1'b0);
    check({tag, "_err"}, err0, 1'b0);
    check({tag, "_waddr1"}, waddr1, 32'd0);
  endtask

  initial begin
    int cnt;
    #1 rst = 1'b1;
    #2 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("idle");

    // Basic load, back-to-back.
    wbuf[0] = 32'h1234_50B7;
    wbuf[1] = 32'h1234_5117;
    do_load(2, 0, 0, 1'b0);
    // Same stream with 3 stall cycles before every byte.
    do_load(2, 3, 3, 1'b0);
    // Zero and overflow counts.
    do_load(0, 0, 0, 1'b0);
    do_load(Depth + 1, 0, 0, 1'b0);
    do_load(16'h0100, 0, 1, 1'b0);
    // Full depth.
    for (int i = 0; i < int'(Depth); i++) wbuf[i] = $urandom;
    do_load(Depth, 0, 1, 1'b0);

    // Reset after the 2nd byte of word 1: no writes expected.
    wbuf[0] = $urandom;
    data_bytes = 0;
    wr_seen = 0;
    pulse_start();
    send_byte(8'd2, 0, 1'b0, 1'b0);
    send_byte(8'd0, 0, 1'b0, 1'b0);
    send_byte(wbuf[0][7:0], 0, 1'b1, 1'b0);
    send_byte(wbuf[0][15:8], 0, 1'b1, 1'b0);
    #3 rst = 1'b1;
    #1 check_reset_outputs("abort");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 check_reset_outputs("post_abort");

    // Fresh stream with start pulses sprinkled through DATA, then re-trigger from DONE.
    for (int i = 0; i < int'(Depth); i++) wbuf[i] = $urandom;
    do_load(5, 0, 2, 1'b1);
    for (int i = 0; i < int'(Depth); i++) wbuf[i] = $urandom;
    do_load(3, 0, 1, 1'b0);

    // Random mix of counts and stalls.
    for (int k = 0; k < 8; k++) begin
      case ($urandom % 4)
        0: cnt = 0;
        1: cnt = $urandom_range(65535, Depth + 1);
        default: cnt = $urandom_range(Depth, 1);
      endcase
      for (int i = 0; i < int'(Depth); i++) wbuf[i] = $urandom;
      do_load(cnt, 0, 2, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
